// File: rtl/axis_byte_packer_pkg.sv
// ============================================================================
// axis_byte_packer_pkg : shared constants and helpers for the AXIS byte packer
// Optional feature macro: AXIS_PACKER_TLAST_EN (consumed by axis_byte_packer)
// Revision: 1.0
// ============================================================================
`default_nettype none

package axis_byte_packer_pkg;

  localparam int BYTE_W = 8;

  // Minimum bit width able to index 0..value-1; never less than 1.
  function automatic int clog2_f(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_byte_packer.sv
// ============================================================================
// axis_byte_packer : packs RATIO narrow AXIS beats into one wide beat, first
// beat in the least-significant lane. Macro AXIS_PACKER_TLAST_EN adds
// tlast/tkeep support with partial-word flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_byte_packer
  import axis_byte_packer_pkg::*;
#(
  parameter int BUS_WIDTH = 1,
  parameter int RATIO     = 4
) (
  input  logic                               aclk,
  input  logic                               arstn,
  input  logic [BUS_WIDTH*BYTE_W-1:0]        s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [BUS_WIDTH*RATIO*BYTE_W-1:0]  m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready
`ifdef AXIS_PACKER_TLAST_EN
  ,
  input  logic                               s_axis_tlast,
  output logic [BUS_WIDTH*RATIO-1:0]         m_axis_tkeep,
  output logic                               m_axis_tlast
`endif
);

  localparam int LANE_W     = BUS_WIDTH * BYTE_W;
  localparam int OUT_WIDTH  = LANE_W * RATIO;
  localparam int KEEP_WIDTH = BUS_WIDTH * RATIO;
  localparam int CNT_WIDTH  = clog2_f(RATIO);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(RATIO - 1);

  logic                 rst_done;
  logic [CNT_WIDTH-1:0] cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_next;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 accept;
  logic                 word_done;

  // Output register can drain and reload in the same cycle.
  assign s_axis_tready = rst_done & (~out_valid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;

`ifdef AXIS_PACKER_TLAST_EN
  logic [KEEP_WIDTH-1:0] keep_next;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;

  assign word_done    = accept & ((cnt == CNT_MAX) | s_axis_tlast);
  assign m_axis_tkeep = out_keep;
  assign m_axis_tlast = out_last;

  always_comb begin
    keep_next = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_WIDTH'(k) <= cnt) keep_next[k*BUS_WIDTH +: BUS_WIDTH] = '1;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      out_keep <= '0;
      out_last <= 1'b0;
    end else if (word_done) begin
      out_keep <= keep_next;
      out_last <= s_axis_tlast;
    end
  end
`else
  assign word_done = accept & (cnt == CNT_MAX);
`endif

  // Merge the incoming beat into its lane; stale upper lanes are kept.
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_WIDTH'(k)) acc_next[k*LANE_W +: LANE_W] = s_axis_tdata;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      rst_done  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        acc <= acc_next;
        cnt <= word_done ? '0 : cnt + CNT_WIDTH'(1);
      end
      if (word_done) begin
        out_data  <= acc_next;
        out_valid <= 1'b1;
      end else if (out_valid && m_axis_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_byte_packer.sv
// ============================================================================
// tb_axis_byte_packer : directed self-checking bench for axis_byte_packer
// (BUS_WIDTH=1, RATIO=4). Extra checks when AXIS_PACKER_TLAST_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_byte_packer;

  logic        aclk;
  logic        arstn;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [3:0]  m_tkeep;
  logic        m_tlast;

  int checks   = 0;
  int failures = 0;

  axis_byte_packer #(
    .BUS_WIDTH (1),
    .RATIO     (4)
  ) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
`ifdef AXIS_PACKER_TLAST_EN
    ,
    .s_axis_tlast  (s_tlast),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast)
`endif
  );

`ifndef AXIS_PACKER_TLAST_EN
  assign m_tkeep = 4'hF;
  assign m_tlast = 1'b0;
`endif

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    step();
  endtask

  int         sent;
  int         words;
  int         cycles;
  logic [7:0] b;
  logic [31:0] exp_word;

  initial begin
    arstn    = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h55;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tdata",  m_tdata,  0);
    arstn    = 1'b1;
    s_tvalid = 1'b0;
    #1;
    chk("rel_s_tready_same_cycle", s_tready, 0);
    step();
    chk("rel_s_tready_next_cycle", s_tready, 1);

    // Basic packing, then stall on the finished word
    beat(8'h01, 1'b0);
    chk("pack_no_valid_b1", m_tvalid, 0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    chk("pack_no_valid_b3", m_tvalid, 0);
    beat(8'h04, 1'b0);
    chk("pack_valid",  m_tvalid, 1);
    chk("pack_tdata",  m_tdata,  32'h04030201);
    chk("pack_tkeep",  m_tkeep,  4'hF);
    chk("pack_tlast",  m_tlast,  0);

    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h05;
    #1;
    chk("bp_s_tready_low", s_tready, 0);
    step();
    step();
    chk("bp_hold_valid", m_tvalid, 1);
    chk("bp_hold_tdata", m_tdata,  32'h04030201);
    chk("bp_s_tready_still_low", s_tready, 0);
    m_tready = 1'b1;
    step();
    chk("bp_release_valid", m_tvalid, 0);
    beat(8'h06, 1'b0);
    beat(8'h07, 1'b0);
    beat(8'h08, 1'b0);
    chk("bp_word2_valid", m_tvalid, 1);
    chk("bp_word2_tdata", m_tdata,  32'h08070605);
    s_tvalid = 1'b0;
    step();
    chk("one_cycle_valid", m_tvalid, 0);

    // Random-handshake stream of incrementing bytes
    sent   = 0;
    words  = 0;
    cycles = 0;
    while (words < 1000 && cycles < 40000) begin
      m_tready = ($urandom_range(0, 3) != 0);
      s_tvalid = (sent < 4000) && ($urandom_range(0, 3) != 0);
      s_tdata  = 8'(sent);
      #1;
      if (m_tvalid && m_tready) begin
        b        = 8'(words * 4);
        exp_word = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        chk("stream_word", m_tdata, exp_word);
        words++;
      end
      if (s_tvalid && s_tready) sent++;
      step();
      cycles++;
    end
    chk("stream_word_count", words, 1000);
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    step();
    chk("stream_drained", m_tvalid, 0);

    // Reset mid-word discards the partial word
    beat(8'hE0, 1'b0);
    beat(8'hE1, 1'b0);
    s_tvalid = 1'b0;
    arstn    = 1'b0;
    #1;
    chk("mid_rst_valid",  m_tvalid, 0);
    chk("mid_rst_tdata",  m_tdata,  0);
    chk("mid_rst_tready", s_tready, 0);
    step();
    arstn = 1'b1;
    step();
    chk("mid_rel_tready", s_tready, 1);
    beat(8'h11, 1'b0);
    beat(8'h12, 1'b0);
    beat(8'h13, 1'b0);
    chk("mid_no_early_valid", m_tvalid, 0);
    beat(8'h14, 1'b0);
    chk("mid_word_valid", m_tvalid, 1);
    chk("mid_word_tdata", m_tdata,  32'h14131211);
    s_tvalid = 1'b0;
    step();

`ifdef AXIS_PACKER_TLAST_EN
    // Partial flush on tlast, then a full word
    beat(8'hA0, 1'b0);
    chk("tl_no_valid", m_tvalid, 0);
    beat(8'hA1, 1'b1);
    chk("tl_valid",      m_tvalid,       1);
    chk("tl_tdata_low",  m_tdata[15:0],  16'hA1A0);
    chk("tl_tkeep",      m_tkeep,        4'b0011);
    chk("tl_tlast",      m_tlast,        1);
    beat(8'hB0, 1'b0);
    chk("tl_cleared", m_tvalid, 0);
    beat(8'hB1, 1'b0);
    beat(8'hB2, 1'b0);
    beat(8'hB3, 1'b0);
    chk("tl_full_valid", m_tvalid, 1);
    chk("tl_full_tdata", m_tdata,  32'hB3B2B1B0);
    chk("tl_full_tkeep", m_tkeep,  4'b1111);
    chk("tl_full_tlast", m_tlast,  0);
    s_tvalid = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
